// File: rtl/param_calculator_if.sv
// Operand, operation-select and result bundle between the board top level
// and the multi-cycle calculator. The board side drives operands and buttons;
// the calculator drives results and the one-hot state decode.
interface param_calculator_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0]   In;
    logic               SCEN;
    logic               ButU;
    logic               ButD;
    logic               ButR;
    logic               ButL;
    logic [2*WIDTH-1:0] Result;
    logic [WIDTH-1:0]   Rem;
    logic               Flag;
    logic               Done;
    logic               QI;
    logic               QGet_A;
    logic               QGet_B;
    logic               QGet_Op;
    logic               QAdd;
    logic               QSub;
    logic               QMul;
    logic               QDiv;
    logic               QErr;
    logic               QDone;

    modport master (
        output In, SCEN, ButU, ButD, ButR, ButL,
        input  Result, Rem, Flag, Done,
        input  QI, QGet_A, QGet_B, QGet_Op, QAdd, QSub, QMul, QDiv, QErr, QDone
    );

    modport slave (
        input  In, SCEN, ButU, ButD, ButR, ButL,
        output Result, Rem, Flag, Done,
        output QI, QGet_A, QGet_B, QGet_Op, QAdd, QSub, QMul, QDiv, QErr, QDone
    );
endinterface

// File: rtl/param_calculator.sv
// Multi-cycle unsigned calculator: captures two operands from the switch bus,
// then performs add, subtract, shift-add multiply or restoring divide.
//
// state     | meaning
// ----------+-----------------------------------------------
// INITIAL   | idle, waiting for confirm to start
// GET_A     | tracking operand A from the switches
// GET_B     | tracking operand B from the switches
// GET_OP    | waiting for an operation button
// ADD       | single-cycle add, carry into Flag
// SUB       | single-cycle subtract, borrow into Flag
// MUL       | WIDTH-cycle LSB-first shift-add multiply
// DIV       | WIDTH-cycle MSB-first restoring divide
// ERR       | divide by zero, waiting for confirm
// DONE      | result valid, waiting for confirm
module param_calculator #(
    parameter int WIDTH = 16
) (
    input logic               Clk,
    input logic               Reset,
    param_calculator_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int W2 = 2 * WIDTH;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [9:0] {
        S_INITIAL = 10'b00_0000_0001,
        S_GET_A   = 10'b00_0000_0010,
        S_GET_B   = 10'b00_0000_0100,
        S_GET_OP  = 10'b00_0000_1000,
        S_ADD     = 10'b00_0001_0000,
        S_SUB     = 10'b00_0010_0000,
        S_MUL     = 10'b00_0100_0000,
        S_DIV     = 10'b00_1000_0000,
        S_ERR     = 10'b01_0000_0000,
        S_DONE    = 10'b10_0000_0000
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [W2-1:0]    result;
    logic [WIDTH-1:0] rem;
    logic [CW-1:0]    cnt;
    logic             flag;
    // upper half: partial remainder, lower half: dividend bits not yet consumed
    logic [W2-1:0]    work;

    logic             last_step;
    logic [WIDTH:0]   add_full;
    logic             mul_bit;
    logic [W2-1:0]    mul_addend;
    logic [W2-1:0]    mul_sum;
    logic [WIDTH:0]   div_trial;
    logic             div_take;
    logic [WIDTH-1:0] div_partial;

    // Arithmetic for the current op step, shared by the datapath register block
    always_comb begin
        last_step   = (cnt == CNT_LAST);
        add_full    = {1'b0, a} + {1'b0, b};
        mul_bit     = |(b & (WIDTH'(1) << cnt));
        mul_addend  = mul_bit ? ({{WIDTH{1'b0}}, a} << cnt) : '0;
        mul_sum     = result + mul_addend;
        div_trial   = work[W2-1:WIDTH-1];
        div_take    = (div_trial >= {1'b0, b});
        // when the trial is taken it is below 2*b, so the difference fits in WIDTH bits
        div_partial = div_take ? (div_trial[WIDTH-1:0] - b) : div_trial[WIDTH-1:0];
    end

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= S_INITIAL;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; buttons only matter in GET_OP, with U > D > R > L
    always_comb begin
        state_next = state;
        case (state)
            S_INITIAL: if (bus.SCEN) state_next = S_GET_A;
            S_GET_A:   if (bus.SCEN) state_next = S_GET_B;
            S_GET_B:   if (bus.SCEN) state_next = S_GET_OP;
            S_GET_OP: begin
                if (bus.ButU)      state_next = S_MUL;
                else if (bus.ButD) state_next = (b == '0) ? S_ERR : S_DIV;
                else if (bus.ButR) state_next = S_ADD;
                else if (bus.ButL) state_next = S_SUB;
            end
            S_ADD:     state_next = S_DONE;
            S_SUB:     state_next = S_DONE;
            S_MUL:     if (last_step) state_next = S_DONE;
            S_DIV:     if (last_step) state_next = S_DONE;
            S_ERR:     if (bus.SCEN) state_next = S_INITIAL;
            S_DONE:    if (bus.SCEN) state_next = S_INITIAL;
            default:   state_next = S_INITIAL;
        endcase
    end

    // Operand capture and per-operation datapath updates
    always_ff @(posedge Clk) begin
        if (Reset) begin
            a      <= '0;
            b      <= '0;
            result <= '0;
            rem    <= '0;
            cnt    <= '0;
            flag   <= 1'b0;
            work   <= '0;
        end else begin
            case (state)
                S_INITIAL: flag <= 1'b0;
                S_GET_A:   a <= bus.In;
                S_GET_B:   b <= bus.In;
                S_GET_OP: begin
                    result <= '0;
                    rem    <= '0;
                    cnt    <= '0;
                    work   <= {{WIDTH{1'b0}}, a};
                end
                S_ADD: begin
                    result <= {{(WIDTH-1){1'b0}}, add_full};
                    flag   <= add_full[WIDTH];
                end
                S_SUB: begin
                    result <= {{WIDTH{1'b0}}, a - b};
                    flag   <= (a < b);
                end
                S_MUL: begin
                    result <= mul_sum;
                    cnt    <= cnt + CW'(1);
                    if (last_step) flag <= |mul_sum[W2-1:WIDTH];
                end
                S_DIV: begin
                    // quotient bits enter at the bottom so the first one ends at WIDTH-1
                    result <= {result[W2-2:0], div_take};
                    work   <= {div_partial, work[WIDTH-2:0], 1'b0};
                    cnt    <= cnt + CW'(1);
                    if (last_step) begin
                        rem  <= div_partial;
                        flag <= 1'b0;
                    end
                end
                S_ERR: begin
                    result <= '0;
                    rem    <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.Result  = result;
    assign bus.Rem     = rem;
    assign bus.Flag    = flag;
    assign bus.Done    = (state == S_DONE);
    assign bus.QI      = (state == S_INITIAL);
    assign bus.QGet_A  = (state == S_GET_A);
    assign bus.QGet_B  = (state == S_GET_B);
    assign bus.QGet_Op = (state == S_GET_OP);
    assign bus.QAdd    = (state == S_ADD);
    assign bus.QSub    = (state == S_SUB);
    assign bus.QMul    = (state == S_MUL);
    assign bus.QDiv    = (state == S_DIV);
    assign bus.QErr    = (state == S_ERR);
    assign bus.QDone   = (state == S_DONE);
endmodule
